prog_loader: RTL and testbench
==============================

# prog_loader

Program-load front end that sits directly upstream of the `gpu` top level. It accepts the kernel program from the host as a stream of 16-bit frames over a valid/ready handshake and assembles them into the flat `data_frames_in` frame buffer. It then strobes `prog_loading` for one cycle so the scheduler captures the program. Unused frame slots are zero-filled, and overflow is flagged.

## Interface
- `DEPTH`, 1024: number of frame slots; must match the `gpu` frame-buffer depth.
- `WIDTH`, 16: frame width in bits.
- `CW`, 11: count width, equal to clog2(`DEPTH`)+1.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `in_valid` in 1: host frame valid.
- `in_ready` out 1: loader can accept a frame.
- `in_frame` in `WIDTH`: frame data.
- `in_last` in 1: marks the final frame of the program; qualified by the handshake.
- `gpu_idle` in 1: the GPU can take a new program; this is the AND of `core_ready` at top level.
- `prog_loading` out 1: one-cycle launch strobe to the scheduler.
- `data_frames_in` out `DEPTH`×`WIDTH`: flat frame buffer. Slot k occupies bits [k*WIDTH +: WIDTH].
- `frame_count` out `CW`: frames stored for the current or last program, saturating at `DEPTH`.
- `overflow` out 1: sticky; set when the current program had more than `DEPTH` frames.

## Operation
- A handshake ("accept") occurs on a rising edge where `in_valid`=1 and `in_ready`=1.
- `in_ready` = (state==IDLE or state==FILL) and not `reset`.

States:
- IDLE: the previous program is held on `data_frames_in`.
  - On accept, all slots clear to 0 and slot 0 is written with `in_frame`.
  - `frame_count` becomes 1 and `overflow` clears.
  - Next state is WAIT if `in_last`=1, otherwise FILL.
- FILL: on accept with `frame_count` < `DEPTH`, slot[`frame_count`] is written and `frame_count` increments.
  - On accept with `frame_count`==`DEPTH`, the frame is dropped, `overflow` sets, and `frame_count` holds at `DEPTH`.
  - If `in_last`=1 on any accept (including a dropped one), next state is WAIT.
- WAIT: `in_ready`=0. At each edge, if `gpu_idle`=1 the state moves to LAUNCH; otherwise it stays in WAIT indefinitely.
- LAUNCH: `prog_loading`=1 for exactly this one cycle and `in_ready`=0. Next state is IDLE unconditionally.

Other rules:
- The buffer is stable from the last accept until the next program's first accept, and remains stable during and after LAUNCH.
- An overflowed program is still launched with its first `DEPTH` frames. `overflow` tells the host the program was truncated.
- `gpu_idle` is ignored outside WAIT.
- Reset, including mid-FILL or mid-WAIT, returns to IDLE and aborts the load with no launch.
  - Reset values: all slots 0, `frame_count`=0, `overflow`=0, `prog_loading`=0, `in_ready`=0 while `reset` is high.
- `in_frame` and `in_last` are don't-care when there is no accept.

## Timing
- `in_ready` is a function of the registered state and `reset` only. It has no combinational path from `in_valid`.
- A frame accepted at edge E is visible on `data_frames_in`, and `frame_count` reflects it, after E.
- Launch latency: last accept at E0 → state WAIT. If `gpu_idle`=1 at E1, `prog_loading` is high from E1 to E2. `in_ready` returns to 1 after E2.
  - The minimum from last accept to strobe is 1 cycle. Each cycle with `gpu_idle`=0 adds 1.
- Throughput is one frame per cycle in FILL. There are no bubbles between back-to-back accepts.
- Minimum load-to-load spacing is 2 dead cycles (WAIT and LAUNCH) with `in_ready`=0.
- `prog_loading` is registered and glitch-free. It is never high for two consecutive cycles.

## Test plan
- **Reset:** hold `reset` 3 cycles with `in_valid`=1 → `in_ready`=0, `prog_loading`=0, `frame_count`=0, all slots 0. The cycle after release, `in_ready`=1.
- **Basic load:** stream 4 frames 0x1111, 0x2222, 0x3333, 0x4444 back-to-back, `in_last` on the 4th, `gpu_idle`=1.
  - Slots 0–3 hold those values and slots 4..1023 are 0.
  - `frame_count`=4.
  - `prog_loading` is high for exactly 1 cycle, 1 cycle after the last accept. Then `in_ready`=1.
- **Busy GPU:** load a single frame 0xBEEF with `in_last`, holding `gpu_idle`=0 for 10 cycles.
  - `in_ready`=0 and `prog_loading`=0 throughout.
  - `prog_loading` pulses on the edge after `gpu_idle` rises.
- **Overflow:** stream 1026 frames, each with value equal to its index, `in_last` on the last.
  - Slots 0..1023 hold 0..1023, `frame_count`=1024, `overflow`=1.
  - The launch strobe still occurs.
  - The next program's first accept clears `overflow` and zeroes slots 1..1023.
- **Reloads:** a 2-frame program after a 4-frame program → slots 2 and 3 read 0. With `in_valid` toggling randomly, only frames accepted while `in_ready`=1 are stored, in order.
- **Reset mid-load:** assert `reset` after 3 of 5 frames → no `prog_loading`, buffer zeroed, `frame_count`=0. A subsequent full load works normally.

Source files
------------

// File: rtl/prog_loader.sv
// Host program loader: packs a valid/ready stream of frames into the
// flat GPU frame buffer and strobes prog_loading once the GPU is idle.
// Ports: clk, reset (sync, active-high); in_valid/in_ready/in_frame/in_last
// host stream; gpu_idle launch gate; prog_loading launch strobe;
// data_frames_in flat buffer (slot k at [k*WIDTH +: WIDTH]);
// frame_count frames stored (saturates at DEPTH); overflow sticky drop flag.
module prog_loader #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 16,
  parameter int CW    = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_frame,
  input  logic                   in_last,
  input  logic                   gpu_idle,
  output logic                   prog_loading,
  output logic [DEPTH*WIDTH-1:0] data_frames_in,
  output logic [CW-1:0]          frame_count,
  output logic                   overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_WAIT,
    S_LAUNCH
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  logic             r_launch;
  logic             w_ready;
  logic             w_accept;
  logic             w_full;

  assign w_ready  = ((r_state == S_IDLE) || (r_state == S_FILL)) && !reset;
  assign w_accept = in_valid && w_ready;
  assign w_full   = (r_count == CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = in_last ? S_WAIT : S_FILL;
      end
      S_FILL: begin
        if (w_accept && in_last) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (gpu_idle) w_next = S_LAUNCH;
      end
      S_LAUNCH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Strobe is a flop loaded from the next-state decode so it is high
  // exactly for the LAUNCH cycle with no combinational glitching.
  always_ff @(posedge clk) begin
    if (reset) r_launch <= 1'b0;
    else       r_launch <= (w_next == S_LAUNCH);
  end

  // The first accept of a program wipes the whole buffer in the same
  // cycle it writes slot 0, so stale frames never leak into a short load.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      if (r_state == S_IDLE) begin
        for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
        r_mem[0] <= in_frame;
        r_count  <= CW'(1);
        r_ovf    <= 1'b0;
      end else if (!w_full) begin
        r_mem[r_count[CW-2:0]] <= in_frame;
        r_count <= r_count + CW'(1);
      end else begin
        r_ovf <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign data_frames_in[g*WIDTH +: WIDTH] = r_mem[g];
  end

  assign in_ready     = w_ready;
  assign prog_loading = r_launch;
  assign frame_count  = r_count;
  assign overflow     = r_ovf;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed and random loads
// compared against a frame-list model of the loader.
module tb_prog_loader;
  localparam int DEPTH = 1024;
  localparam int WIDTH = 16;
  localparam int CW    = 11;

  logic                   clk = 0;
  logic                   reset = 1;
  logic                   in_valid = 0;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_frame = '0;
  logic                   in_last = 0;
  logic                   gpu_idle = 0;
  logic                   prog_loading;
  logic [DEPTH*WIDTH-1:0] data_frames_in;
  logic [CW-1:0]          frame_count;
  logic                   overflow;

  prog_loader #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_frame(in_frame), .in_last(in_last),
    .gpu_idle(gpu_idle), .prog_loading(prog_loading),
    .data_frames_in(data_frames_in),
    .frame_count(frame_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: stored program as a list of frames plus a phase:
  // 0 = taking frames, 1 = program complete awaiting GPU, 2 = launching.
  logic [WIDTH-1:0] m_mem [DEPTH];
  int m_cnt = 0;
  int m_ovf = 0;
  int m_phase = 0;
  int m_fresh = 1;
  int strobes = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_buf(string tag);
    logic [DEPTH*WIDTH-1:0] e;
    int bad;
    bad = -1;
    for (int k = 0; k < DEPTH; k++) begin
      e[k*WIDTH +: WIDTH] = m_mem[k];
      if (bad < 0 && data_frames_in[k*WIDTH +: WIDTH] !== m_mem[k]) bad = k;
    end
    n_cmp++;
    assert (data_frames_in === e) else begin
      n_err++;
      if (bad < 0) bad = 0;
      $error("FAIL %s: slot %0d got %0h expected %0h", tag, bad,
             data_frames_in[bad*WIDTH +: WIDTH], m_mem[bad]);
    end
  endtask

  task automatic model_edge();
    bit rdy, acc;
    rdy = !reset && (m_phase == 0);
    acc = in_valid && rdy;
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
      m_cnt = 0; m_ovf = 0; m_phase = 0; m_fresh = 1;
    end else if (m_phase == 2) begin
      m_phase = 0;
    end else if (m_phase == 1) begin
      if (gpu_idle) m_phase = 2;
    end else if (acc) begin
      if (m_fresh) begin
        for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
        m_mem[0] = in_frame;
        m_cnt = 1; m_ovf = 0; m_fresh = 0;
      end else if (m_cnt < DEPTH) begin
        m_mem[m_cnt] = in_frame;
        m_cnt++;
      end else begin
        m_ovf = 1;
      end
      if (in_last) begin
        m_phase = 1; m_fresh = 1;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    if (prog_loading === 1'b1) strobes++;
    chk("in_ready", in_ready, !reset && m_phase == 0);
    chk("prog_loading", prog_loading, m_phase == 2);
    chk("frame_count", frame_count, m_cnt);
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic send(logic [WIDTH-1:0] f, bit last);
    in_valid = 1; in_frame = f; in_last = last;
    tick();
    in_valid = 0; in_frame = WIDTH'($urandom); in_last = 1'($urandom);
  endtask

  task automatic idle_cycles(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int s0;
    // Reset with valid held high
    reset = 1; in_valid = 1; in_frame = 16'hDEAD; gpu_idle = 1;
    for (int i = 0; i < 3; i++) tick();
    chk_buf("reset_buf");
    reset = 0; in_valid = 0;
    tick();
    chk("ready_after_reset", in_ready, 1);

    // Basic 4-frame load
    gpu_idle = 1;
    s0 = strobes;
    send(16'h1111, 0);
    send(16'h2222, 0);
    send(16'h3333, 0);
    send(16'h4444, 1);
    chk_buf("basic_buf");
    tick();
    chk("basic_strobe_now", prog_loading, 1);
    tick();
    chk("basic_ready_back", in_ready, 1);
    chk("basic_one_strobe", strobes - s0, 1);
    chk("basic_cnt", frame_count, 4);

    // Busy GPU
    gpu_idle = 0;
    s0 = strobes;
    send(16'hBEEF, 1);
    idle_cycles(10);
    chk("busy_no_strobe", strobes - s0, 0);
    gpu_idle = 1;
    tick();
    chk("busy_strobe", prog_loading, 1);
    gpu_idle = 0;
    idle_cycles(2);
    chk_buf("busy_buf");

    // Overflow: 1026 frames valued by index
    gpu_idle = 1;
    s0 = strobes;
    for (int i = 0; i < 1026; i++) send(WIDTH'(i), i == 1025);
    chk_buf("ovf_buf");
    chk("ovf_cnt", frame_count, DEPTH);
    chk("ovf_flag", overflow, 1);
    idle_cycles(3);
    chk("ovf_strobe", strobes - s0, 1);
    send(16'h0A0A, 0);
    chk("ovf_cleared", overflow, 0);
    chk_buf("ovf_reload_buf");
    send(16'h0B0B, 1);
    idle_cycles(3);

    // 4-frame then 2-frame reload
    for (int i = 0; i < 4; i++) send(WIDTH'($urandom), i == 3);
    idle_cycles(2);
    for (int i = 0; i < 2; i++) send(WIDTH'($urandom), i == 1);
    chk_buf("reload_short_buf");
    idle_cycles(2);

    // Random valid/last/gpu_idle traffic
    for (int i = 0; i < 600; i++) begin
      in_valid = 1'($urandom);
      in_frame = WIDTH'($urandom);
      in_last  = ($urandom_range(0, 9) == 0);
      gpu_idle = 1'($urandom);
      tick();
      if (i % 100 == 99) chk_buf("rand_buf");
    end
    in_valid = 0; gpu_idle = 1;
    idle_cycles(4);
    chk_buf("rand_end_buf");

    // Reset mid-load
    s0 = strobes;
    for (int i = 0; i < 3; i++) send(WIDTH'(16'h5000 + i), 0);
    reset = 1;
    tick();
    reset = 0;
    idle_cycles(3);
    chk("midrst_no_strobe", strobes - s0, 0);
    chk_buf("midrst_buf");
    for (int i = 0; i < 5; i++) send(WIDTH'(16'h6000 + i), i == 4);
    chk_buf("after_rst_buf");
    idle_cycles(3);
    chk("after_rst_strobe", strobes - s0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
